// File: rtl/uart_tx_fifo_cfg.sv
// UART transmit path: FIFO buffer, free-running 16x baud tick and a configurable
// serialiser (5..9 data bits, none/even/odd parity, 1 or 2 stop bits).
module uart_tx_fifo_cfg #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 clr_ovf,
  output logic                 tx,
  output logic                 full,
  output logic                 empty,
  output logic [FIFO_AW:0]     level,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 ovf_flag
);

  localparam int               TICK_DIV  = CLK_HZ / (BAUD * 16);
  localparam int               TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam int               LW        = FIFO_AW + 1;
  localparam logic [FIFO_AW:0] DEPTH     = LW'(2 ** FIFO_AW);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    if (PARITY == 2) return ~^d;
    else             return ^d;
  endfunction

  logic [TW-1:0]        r_tick_cnt;
  logic                 w_tick;
  logic [DATA_BITS-1:0] r_mem [0:2**FIFO_AW-1];
  logic [FIFO_AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [FIFO_AW:0]     r_level, w_level_nxt;
  logic                 r_full, r_empty, r_ovf;
  logic                 w_wr, w_drop, w_pop;
  logic [DATA_BITS-1:0] w_head;
  state_t               r_state, w_state_nxt;
  logic [3:0]           r_bit_tick, w_bit_tick_nxt;
  logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic                 r_par, w_par_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy, r_done, w_done_nxt;
  logic                 w_bit_end;

  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_wr      = push & ~r_full;
  assign w_drop    = push & r_full;
  assign w_pop     = (r_state == S_IDLE) & ~r_empty;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_bit_end = w_tick & (r_bit_tick == 4'd15);

  // Baud tick runs freely; a frame start never realigns it.
  always_ff @(posedge clk) begin
    if (!reset)      r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= push_data;
  end

  always_comb begin
    w_level_nxt = r_level;
    case ({w_wr, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // A dropped push sets the overflow flag even when clr_ovf arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == DEPTH);
      r_empty <= (w_level_nxt == '0);
      if (w_drop)       r_ovf <= 1'b1;
      else if (clr_ovf) r_ovf <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shift_nxt    = r_shift;
    w_par_nxt      = r_par;
    w_done_nxt     = 1'b0;
    w_bit_tick_nxt = w_tick ? r_bit_tick + 4'd1 : r_bit_tick;
    case (r_state)
      S_IDLE: begin
        w_bit_tick_nxt = 4'd0;
        w_bit_cnt_nxt  = 4'd0;
        if (!r_empty) begin
          w_state_nxt = S_START;
          w_shift_nxt = w_head;
          w_par_nxt   = parity_bit(w_head);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_bit_end) w_state_nxt = S_DATA;
        else           w_state_nxt = S_START;
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit_cnt == LAST_DATA) begin
            w_bit_cnt_nxt = 4'd0;
            w_state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_bit_end) w_state_nxt = S_STOP;
        else           w_state_nxt = S_PARITY;
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_bit_cnt == LAST_STOP) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
          end
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Line level is registered alongside the state it belongs to.
    case (w_state_nxt)
      S_IDLE:   w_tx_nxt = 1'b1;
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shift_nxt[0];
      S_PARITY: w_tx_nxt = w_par_nxt;
      S_STOP:   w_tx_nxt = 1'b1;
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_bit_tick <= 4'd0;
      r_bit_cnt  <= 4'd0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_bit_tick <= w_bit_tick_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_par      <= w_par_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
    end
  end

  assign tx       = r_tx;
  assign full     = r_full;
  assign empty    = r_empty;
  assign level    = r_level;
  assign tx_busy  = r_busy;
  assign tx_done  = r_done;
  assign ovf_flag = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: an 8N1 instance with a 4-deep FIFO and a 7E2 instance
// with an 8-deep FIFO, checked against a queue model and a mid-bit line decoder.
module tb_uart_tx_fifo_cfg;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 1_562_500;
  localparam int TD     = CLK_HZ / (BAUD * 16);
  localparam int BIT    = 16 * TD;

  logic       clk, reset;
  logic       push_a, clr_a, push_b, clr_b;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic       tx_a, full_a, empty_a, busy_a, done_a, ovf_a;
  logic       tx_b, full_b, empty_b, busy_b, done_b, ovf_b;
  logic [2:0] level_a;
  logic [3:0] level_b;

  uart_tx_fifo_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0),
                     .STOP_BITS(1), .FIFO_AW(2)) u_dut_a (
    .clk(clk), .reset(reset), .push(push_a), .push_data(data_a), .clr_ovf(clr_a),
    .tx(tx_a), .full(full_a), .empty(empty_a), .level(level_a), .tx_busy(busy_a),
    .tx_done(done_a), .ovf_flag(ovf_a));

  uart_tx_fifo_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1),
                     .STOP_BITS(2), .FIFO_AW(3)) u_dut_b (
    .clk(clk), .reset(reset), .push(push_b), .push_data(data_b), .clr_ovf(clr_b),
    .tx(tx_b), .full(full_b), .empty(empty_b), .level(level_b), .tx_busy(busy_b),
    .tx_done(done_b), .ovf_flag(ovf_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cnt_m[2];
  bit busy_m[2];
  bit ovf_m[2];
  int accepted[2];
  int done_cnt[2];
  int dbl_cnt[2];
  logic prev_done_a = 1'b0;
  logic prev_done_b = 1'b0;
  logic [8:0] q_a[$];
  logic [8:0] q_b[$];
  logic [8:0] words[16];
  logic [15:0] got;
  int bad;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      done_cnt[0]++;
      if (prev_done_a) dbl_cnt[0]++;
    end
    if (done_b) begin
      done_cnt[1]++;
      if (prev_done_b) dbl_cnt[1]++;
    end
    prev_done_a = done_a;
    prev_done_b = done_b;
  end

  function automatic int depth_of(input int s);
    return (s == 0) ? 4 : 8;
  endfunction

  function automatic logic line_of(input int s);
    return (s == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic done_of(input int s);
    return (s == 0) ? done_a : done_b;
  endfunction

  function automatic int level_of(input int s);
    return (s == 0) ? int'(level_a) : int'(level_b);
  endfunction

  function automatic logic [3:0] flags_of(input int s);
    return (s == 0) ? {full_a, empty_a, busy_a, ovf_a} : {full_b, empty_b, busy_b, ovf_b};
  endfunction

  // Expected line bits, index 0 = start bit, from the frame format rules.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int s);
    logic [15:0] f;
    int nd, pos, ones;
    f = '0;
    ones = 0;
    nd = (s == 0) ? 8 : 7;
    for (int i = 0; i < nd; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    pos = 1 + nd;
    if (s == 1) begin
      f[pos] = ((ones % 2) == 1);
      pos++;
    end
    f[pos] = 1'b1;
    if (s == 1) f[pos+1] = 1'b1;
    return f;
  endfunction

  task automatic drive(input int s, input bit pu, input logic [8:0] d, input bit clr);
    if (s == 0) begin
      push_a = pu; data_a = d[7:0]; clr_a = clr;
    end else begin
      push_b = pu; data_b = d[6:0]; clr_b = clr;
    end
  endtask

  task automatic model_edge(input int s, input bit pu, input logic [8:0] d, input bit clr, input bit pop);
    bit was_full;
    was_full = (cnt_m[s] == depth_of(s));
    if (pu && was_full) ovf_m[s] = 1'b1;
    else if (clr)       ovf_m[s] = 1'b0;
    if (pu && !was_full) begin
      cnt_m[s]++;
      accepted[s]++;
      if (s == 0) q_a.push_back(d);
      else        q_b.push_back(d);
    end
    if (pop) begin
      cnt_m[s]--;
      busy_m[s] = 1'b1;
    end
  endtask

  task automatic check_state(input int s, input string tag);
    logic [3:0] ef;
    ef = {cnt_m[s] == depth_of(s), cnt_m[s] == 0, busy_m[s], ovf_m[s]};
    check_eq({tag, "_level"}, level_of(s), cnt_m[s]);
    check_eq({tag, "_flags"}, flags_of(s), ef);
  endtask

  // Pushes k words from words[]; an idle serialiser pops the head one edge after it lands.
  task automatic push_burst(input int s, input int k, input bit gaps);
    int sent, gap;
    bit pu, pop;
    logic [8:0] d;
    sent = 0;
    gap = 0;
    @(negedge clk);
    while (sent < k || (!busy_m[s] && cnt_m[s] > 0)) begin
      pu = (sent < k) && (gap == 0);
      d = words[sent] & ((s == 0) ? 9'h0FF : 9'h07F);
      if (pu) begin
        sent++;
        gap = gaps ? int'($urandom_range(0, 2)) : 0;
      end else if (gap > 0) begin
        gap--;
      end
      drive(s, pu, d, 1'b0);
      @(posedge clk);
      pop = !busy_m[s] && (cnt_m[s] > 0);
      model_edge(s, pu, d, 1'b0, pop);
      @(negedge clk);
      drive(s, 1'b0, 9'h000, 1'b0);
      check_state(s, "burst");
    end
  endtask

  task automatic rx_capture(input int s, output logic [15:0] bits);
    int t, nb;
    t = 0;
    nb = (s == 0) ? 10 : 11;
    bits = '0;
    while (line_of(s) !== 1'b0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (line_of(s) !== 1'b0) begin
      check_eq("rx_start", line_of(s), 0);
    end else begin
      repeat (BIT / 2) @(negedge clk);
      bits[0] = line_of(s);
      for (int i = 1; i < nb; i++) begin
        repeat (BIT) @(negedge clk);
        bits[i] = line_of(s);
      end
    end
  endtask

  task automatic rx_check(input int s);
    logic [15:0] bits;
    logic [8:0] d;
    int qs;
    rx_capture(s, bits);
    qs = (s == 0) ? q_a.size() : q_b.size();
    if (qs == 0) begin
      check_eq("rx_queue_size", qs, 1);
    end else begin
      d = (s == 0) ? q_a.pop_front() : q_b.pop_front();
      check_eq("rx_frame", bits, frame_bits(d, s));
    end
  endtask

  task automatic rx_drain(input int s);
    while (((s == 0) ? q_a.size() : q_b.size()) > 0) rx_check(s);
  endtask

  task automatic wait_done(input int s);
    int t;
    t = 0;
    while (done_of(s) !== 1'b1 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (done_of(s) !== 1'b1) check_eq("tx_done_wait", done_of(s), 1);
  endtask

  // Push during the tx_done cycle so it coincides with the pop of the next word.
  task automatic push_at_pop(input int s, input logic [8:0] d, input bit clr);
    drive(s, 1'b1, d, clr);
    @(posedge clk);
    model_edge(s, 1'b1, d, clr, 1'b1);
    @(negedge clk);
    drive(s, 1'b0, 9'h000, 1'b0);
    check_state(s, "push_pop");
  endtask

  // Serialiser has finished everything queued: FIFO drained, one done pulse per accepted word.
  task automatic settle(input int s);
    repeat (BIT) @(negedge clk);
    cnt_m[s] = 0;
    busy_m[s] = 1'b0;
    check_state(s, "settle");
    check_eq("done_count", done_cnt[s], accepted[s]);
    check_eq("done_width", dbl_cnt[s], 0);
    if (ovf_m[s]) begin
      drive(s, 1'b0, 9'h000, 1'b1);
      @(posedge clk);
      model_edge(s, 1'b0, 9'h000, 1'b1, 1'b0);
      @(negedge clk);
      drive(s, 1'b0, 9'h000, 1'b0);
      check_state(s, "clr_ovf");
    end
  endtask

  task automatic random_round(input int s, input int kmax);
    int k;
    k = int'($urandom_range(1, kmax));
    for (int i = 0; i < 16; i++) words[i] = 9'($urandom);
    fork
      push_burst(s, k, 1'b1);
      rx_check(s);
    join
    rx_drain(s);
    settle(s);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    push_a = 1'b0; clr_a = 1'b0; data_a = 8'h00;
    push_b = 1'b0; clr_b = 1'b0; data_b = 7'h00;
    for (int s = 0; s < 2; s++) begin
      cnt_m[s] = 0; busy_m[s] = 1'b0; ovf_m[s] = 1'b0;
      accepted[s] = 0; done_cnt[s] = 0; dbl_cnt[s] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_tx", {tx_a, tx_b, done_a, done_b}, 4'b1100);
    check_state(0, "reset_a");
    check_state(1, "reset_b");
    reset = 1'b1;

    bad = 0;
    repeat (10_000) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || empty_a !== 1'b1 || level_a !== 3'd0 || busy_a !== 1'b0) bad++;
    end
    check_eq("idle_quiet", bad, 0);

    words[0] = 9'h0A5;
    fork
      push_burst(0, 1, 1'b0);
      rx_capture(0, got);
    join
    check_eq("frame_8n1_a5", got, 16'h034A);
    void'(q_a.pop_front());
    settle(0);

    words[0] = 9'h035;
    fork
      push_burst(1, 1, 1'b0);
      rx_capture(1, got);
    join
    check_eq("frame_7e2_35", got, 16'h066A);
    void'(q_b.pop_front());
    settle(1);

    for (int i = 0; i < 6; i++) words[i] = 9'(8'h11 * (i + 1));
    fork
      push_burst(0, 6, 1'b0);
      rx_check(0);
    join
    check_eq("ovf_after_burst", ovf_a, 1);
    rx_drain(0);
    settle(0);

    words[0] = 9'h001; words[1] = 9'h002; words[2] = 9'h003;
    push_burst(0, 3, 1'b0);
    wait_done(0);
    push_at_pop(0, 9'h004, 1'b0);
    words[0] = 9'h005; words[1] = 9'h006;
    push_burst(0, 2, 1'b0);
    wait_done(0);
    push_at_pop(0, 9'h007, 1'b1);
    repeat (5 * 10 * BIT) @(negedge clk);
    q_a.delete();
    settle(0);

    words[0] = 9'h0FF;
    push_burst(0, 1, 1'b0);
    check_eq("start_latency", tx_a, 0);
    repeat (4 * BIT + BIT / 2) @(negedge clk);
    check_eq("abort_pre", {tx_a, busy_a}, 2'b11);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      cnt_m[s] = 0; busy_m[s] = 1'b0; ovf_m[s] = 1'b0;
    end
    accepted[0]--;
    q_a.delete();
    check_eq("abort_tx", tx_a, 1);
    check_state(0, "abort");
    reset = 1'b1;
    bad = 0;
    repeat (3000) begin
      @(negedge clk);
      if (tx_a !== 1'b1) bad++;
    end
    check_eq("abort_line_idle", bad, 0);
    check_eq("abort_no_done", done_cnt[0], accepted[0]);
    words[0] = 9'h03C;
    fork
      push_burst(0, 1, 1'b0);
      rx_check(0);
    join
    settle(0);

    repeat (6) random_round(0, 7);
    repeat (2) random_round(1, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
